// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS registers with byte-strobed writes and live register outputs.
// Optional macro AXI4_LITE_REGFILE_SLVERR_EN: invalid addresses answer SLVERR instead of OKAY.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_BAD = 2'b10;
`else
  localparam logic [1:0] RESP_BAD = 2'b00;
`endif

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < SPAN) && (a[LSB-1:0] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: IDX_W];
  endfunction

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_fire, w_fire, ar_fire, do_write;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;

  // Readies are held low while reset is asserted so nothing handshakes during reset.
  assign awready = !areset && !aw_held_q && !bvalid_q;
  assign wready  = !areset && !w_held_q && !bvalid_q;
  assign arready = !areset && !rvalid_q;

  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign ar_fire  = arvalid && arready;
  assign do_write = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign wr_addr  = aw_held_q ? awaddr_q : awaddr;
  assign wr_data  = w_held_q ? wdata_q : wdata;
  assign wr_strb  = w_held_q ? wstrb_q : wstrb;
  assign wr_idx   = addr_idx(wr_addr);

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;

    if (do_write) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (addr_ok(wr_addr)) begin
        bresp_d = RESP_OKAY;
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end else begin
        bresp_d = RESP_BAD;
      end
    end else begin
      if (aw_fire) begin
        aw_held_d = 1'b1;
        awaddr_d  = awaddr;
      end
      if (w_fire) begin
        w_held_d = 1'b1;
        wdata_d  = wdata;
        wstrb_d  = wstrb;
      end
      if (bvalid_q && bready) begin
        bvalid_d = 1'b0;
        bresp_d  = RESP_OKAY;
      end
    end

    // Reads sample regs_q, so a same-edge write is not visible to this read.
    if (ar_fire) begin
      rvalid_d = 1'b1;
      if (addr_ok(araddr)) begin
        rdata_d = regs_q[addr_idx(araddr)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_BAD;
      end
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile: directed scenarios plus randomized traffic
// compared against an array-based register model.
module tb_axi4_lite_regfile;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 8;
`ifdef AXI4_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] BAD = 2'b10;
`else
  localparam logic [1:0] BAD = 2'b00;
`endif

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [AW-1:0]    awaddr = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  wstrb = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [AW-1:0]    araddr = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready = 1'b0;
  logic [NR*DW-1:0] regs_o;

  always #5 aclk = ~aclk;

  axi4_lite_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mem [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit in_map(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < NR);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, 64'(regs_o[i*DW +: DW]), 64'(mem[i]));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done;
    int cyc;
    logic [1:0] er;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awaddr  = addr; wdata = data; wstrb = strb;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      #1;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      tick();
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", 64'({aw_done, w_done}), 64'd3);
    if (in_map(addr)) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mem[addr / 4][8*b +: 8] = data[8*b +: 8];
      er = 2'b00;
    end else begin
      er = BAD;
    end
    check("bvalid", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), 64'(er));
    check_regs("wr_regs");
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", 64'(bvalid), 64'd1);
      check("bresp_hold", 64'(bresp), 64'(er));
      check("aw_w_blocked", 64'({awready, wready}), 64'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_clr", 64'(bvalid), 64'd0);
    check("aw_w_ready_back", 64'({awready, wready}), 64'd3);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly, output logic [31:0] got);
    logic [31:0] ed;
    logic [1:0]  er;
    if (in_map(addr)) begin ed = mem[addr / 4]; er = 2'b00; end
    else begin ed = 32'd0; er = BAD; end
    check("rdata_idle", 64'(rdata), 64'd0);
    araddr = addr; arvalid = 1'b1;
    #1;
    check("arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    got = rdata;
    check("rvalid", 64'(rvalid), 64'd1);
    check("rdata", 64'(rdata), 64'(ed));
    check("rresp", 64'(rresp), 64'(er));
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rdata_hold", 64'({rvalid, arready, rdata}), 64'({2'b10, ed}));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_clr", 64'(rvalid), 64'd0);
    check("rdata_clr", 64'(rdata), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, old, a;
    int pick;
    for (int i = 0; i < NR; i++) mem[i] = 32'd0;

    // Reset state and first cycle afterwards
    tick();
    tick();
    check("rst_readies", 64'({awready, wready, arready}), 64'd0);
    check("rst_valids", 64'({bvalid, rvalid}), 64'd0);
    check("rst_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
    check("rst_regs", 64'(|regs_o), 64'd0);
    areset = 1'b0;
    #1;
    check("post_rst_readies", 64'({awready, wready, arready}), 64'd7);
    tick();

    // AW first, W three cycles later
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    check("aw_then_w_reg1", 64'(regs_o[1*DW +: DW]), 64'hDEADBEEF);
    // Zero strobe leaves the register untouched
    do_write(32'h04, 32'h12345678, 4'h0, 0, 0, 1);
    check("zero_strb_reg1", 64'(regs_o[1*DW +: DW]), 64'hDEADBEEF);

    // Partial strobe merge
    do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h08, 32'h11223344, 4'h5, 0, 0, 0);
    check("strb_merge_reg2", 64'(regs_o[2*DW +: DW]), 64'hAA22CC44);
    do_read(32'h08, 1, rd);
    check("strb_merge_read", 64'(rd), 64'hAA22CC44);

    // Stalled write response, then immediate next write
    do_write(32'h1C, 32'h00000077, 4'hF, 0, 0, 5);
    do_write(32'h18, 32'h00000066, 4'hF, 0, 1, 0);

    // Invalid addresses
    do_read(32'h40, 0, rd);
    check("oor_rdata", 64'(rd), 64'd0);
    do_read(32'h06, 2, rd);
    check("misalign_rdata", 64'(rd), 64'd0);
    do_write(32'h42, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    check_regs("invalid_no_change");

    // Write and read of the same register on the same edge
    do_write(32'h0C, 32'hCAFE0003, 4'hF, 0, 0, 0);
    old = mem[3];
    awaddr = 32'h0C; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mem[3] = 32'h5;
    check("same_edge_rdata", 64'(rdata), 64'(old));
    check("same_edge_reg3", 64'(regs_o[3*DW +: DW]), 64'h5);
    check("same_edge_valids", 64'({bvalid, rvalid}), 64'd3);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(32'h0C, 0, rd);
    check("same_edge_reread", 64'(rd), 64'h5);

    // Reset while AW is held and a read response is pending
    awaddr = 32'h10; awvalid = 1'b1; araddr = 32'h04; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_pending", 64'({rvalid, awready, wready}), 64'd5);
    areset = 1'b1;
    tick();
    check("mid_rst_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    check("mid_rst_regs", 64'(|regs_o), 64'd0);
    for (int i = 0; i < NR; i++) mem[i] = 32'd0;
    areset = 1'b0;
    #1;
    check("after_rst_readies", 64'({awready, wready, arready}), 64'd7);
    tick();
    do_write(32'h14, 32'h600DF00D, 4'hF, 3, 0, 0);
    check("no_stale_reg4", 64'(regs_o[4*DW +: DW]), 64'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      pick = $urandom_range(0, 9);
      if (pick < 7) a = 32'($urandom_range(0, NR - 1) * 4);
      else if (pick == 7) a = $urandom | 32'h100;
      else a = 32'($urandom_range(0, NR - 1) * 4) | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2), rd);
    end
    check_regs("final_regs");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
